// File: rtl/alu_arith_dispatch.sv
// alu_arith_dispatch: runs one arithmetic op across THREADS lanes through a
// single shared combinational arithmetic unit, one lane per clock cycle.
//
// Handshake: start is a level request that is sampled only in IDLE. A start
// seen while busy is dropped, not queued. done is a one-cycle pulse that
// marks result_vec/div_zero_mask as valid. Those outputs then hold until the
// next accepted start or reset.
//
// The FSM state is the enum-typed signal `state`. A checker can bind to it
// hierarchically to follow IDLE/ISSUE/DONE.
module alu_arith_dispatch #(
    parameter int WIDTH   = 8,
    parameter int THREADS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               op_sel,
    input  logic [THREADS*WIDTH-1:0] rs_vec,
    input  logic [THREADS*WIDTH-1:0] rt_vec,
    output logic [1:0]               AluArithmeticMux,
    output logic [WIDTH-1:0]         rs,
    output logic [WIDTH-1:0]         rt,
    input  logic [WIDTH-1:0]         ArithOut,
    output logic                     busy,
    output logic                     done,
    output logic [THREADS*WIDTH-1:0] result_vec,
    output logic [THREADS-1:0]       div_zero_mask
);

    localparam int IDXW = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(THREADS - 1);
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IDXW-1:0] idx;
    logic [1:0]      op_q;
    logic [WIDTH-1:0] rs_q  [THREADS];
    logic [WIDTH-1:0] rt_q  [THREADS];
    logic [WIDTH-1:0] res_q [THREADS];
    logic            last_lane;
    logic            div_by_zero;

    assign last_lane   = (idx == LAST_IDX);
    // A zero divisor is decided from the latched operand. The unit's result is not used for this.
    assign div_by_zero = (op_q == OP_DIV) && (rt_q[idx] == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, plus the operand/op-select drive to the arithmetic unit.
    always_comb begin
        state_next       = state;
        busy             = 1'b0;
        done             = 1'b0;
        AluArithmeticMux = 2'b00;
        rs               = '0;
        rt               = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                busy             = 1'b1;
                AluArithmeticMux = op_q;
                rs               = rs_q[idx];
                rt               = rt_q[idx];
                if (last_lane) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch at start, then per-lane result capture while ISSUE runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx           <= '0;
            op_q          <= 2'b00;
            div_zero_mask <= '0;
            for (int i = 0; i < THREADS; i++) begin
                rs_q[i]  <= '0;
                rt_q[i]  <= '0;
                res_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q          <= op_sel;
                        idx           <= '0;
                        div_zero_mask <= '0;
                        for (int i = 0; i < THREADS; i++) begin
                            rs_q[i] <= rs_vec[i*WIDTH +: WIDTH];
                            rt_q[i] <= rt_vec[i*WIDTH +: WIDTH];
                        end
                    end
                end
                ISSUE: begin
                    if (div_by_zero) begin
                        res_q[idx]         <= '1;
                        div_zero_mask[idx] <= 1'b1;
                    end else begin
                        res_q[idx] <= ArithOut;
                    end
                    if (!last_lane) begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pack the per-lane result registers into the flat output vector.
    always_comb begin
        result_vec = '0;
        for (int i = 0; i < THREADS; i++) begin
            result_vec[i*WIDTH +: WIDTH] = res_q[i];
        end
    end

endmodule

// File: tb/tb_alu_arith_dispatch.sv
// tb_alu_arith_dispatch: directed and randomized checks of the lane-serial dispatcher.
// The bench also plays the combinational arithmetic unit.
module tb_alu_arith_dispatch;

    localparam int W = 8;
    localparam int T = 4;

    logic           clk;
    logic           reset;
    logic           start;
    logic [1:0]     op_sel;
    logic [T*W-1:0] rs_vec;
    logic [T*W-1:0] rt_vec;
    logic [1:0]     alu_mux;
    logic [W-1:0]   rs;
    logic [W-1:0]   rt;
    logic [W-1:0]   arith_out;
    logic           busy;
    logic           done;
    logic [T*W-1:0] result_vec;
    logic [T-1:0]   div_zero_mask;

    int tests;
    int fails;

    alu_arith_dispatch #(.WIDTH(W), .THREADS(T)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .op_sel           (op_sel),
        .rs_vec           (rs_vec),
        .rt_vec           (rt_vec),
        .AluArithmeticMux (alu_mux),
        .rs               (rs),
        .rt               (rt),
        .ArithOut         (arith_out),
        .busy             (busy),
        .done             (done),
        .result_vec       (result_vec),
        .div_zero_mask    (div_zero_mask)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External arithmetic unit. A zero divisor returns 0x5A, so the dispatcher's override can be observed.
    always_comb begin
        case (alu_mux)
            2'b00:   arith_out = rs + rt;
            2'b01:   arith_out = rs - rt;
            2'b10:   arith_out = rs * rt;
            default: arith_out = (rt == '0) ? 8'h5A : rs / rt;
        endcase
    end

    // Reference lane result, computed with integer arithmetic modulo 256.
    function automatic logic [W-1:0] ref_lane(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        int ai;
        int bi;
        int r;
        ai = int'(a);
        bi = int'(b);
        case (op)
            2'd0:    r = (ai + bi) % 256;
            2'd1:    r = (ai - bi + 256) % 256;
            2'd2:    r = (ai * bi) % 256;
            default: r = (bi == 0) ? 255 : ai / bi;
        endcase
        return W'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one run. Call this at a negedge in IDLE. It returns at a negedge in IDLE, after done.
    task automatic run_op(input logic [1:0] op, input logic [T*W-1:0] a, input logic [T*W-1:0] b,
                          input bit scramble);
        logic [T*W-1:0] exp_res;
        logic [T-1:0]   exp_mask;
        exp_res  = '0;
        exp_mask = '0;
        for (int k = 0; k < T; k++) begin
            exp_res[k*W +: W] = ref_lane(op, a[k*W +: W], b[k*W +: W]);
            exp_mask[k]       = (op == 2'd3) && (b[k*W +: W] == 8'd0);
        end
        start  = 1'b1;
        op_sel = op;
        rs_vec = a;
        rt_vec = b;
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            rs_vec = $urandom;
            rt_vec = $urandom;
            op_sel = 2'($urandom_range(0, 3));
        end
        for (int k = 0; k < T; k++) begin
            chk($sformatf("busy_l%0d", k), 32'(busy), 32'd1);
            chk($sformatf("done_l%0d", k), 32'(done), 32'd0);
            chk($sformatf("mux_l%0d", k), 32'(alu_mux), 32'(op));
            chk($sformatf("rs_l%0d", k), 32'(rs), 32'(a[k*W +: W]));
            chk($sformatf("rt_l%0d", k), 32'(rt), 32'(b[k*W +: W]));
            @(negedge clk);
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("result_vec", result_vec, exp_res);
        chk("div_zero_mask", 32'(div_zero_mask), 32'(exp_mask));
        @(negedge clk);
        chk("done_clear", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("result_hold", result_vec, exp_res);
    endtask

    // Linear directed sequence, followed by randomized runs.
    initial begin
        int done_cnt;
        int p;
        logic [T*W-1:0] ra;
        logic [T*W-1:0] rb;
        tests  = 0;
        fails  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op_sel = 2'b00;
        rs_vec = '0;
        rt_vec = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mux", 32'(alu_mux), 32'd0);
        chk("rst_rs", 32'(rs), 32'd0);
        chk("rst_rt", 32'(rt), 32'd0);
        chk("rst_result", result_vec, 32'd0);
        chk("rst_mask", 32'(div_zero_mask), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ADD with a wrap in lane 3.
        run_op(2'd0, {8'd255, 8'd30, 8'd20, 8'd10}, {8'd1, 8'd3, 8'd2, 8'd1}, 1'b0);
        chk("add_const", result_vec, 32'h0021160B);
        chk("add_mask", 32'(div_zero_mask), 32'd0);

        // DIV with a zero divisor in lane 1.
        run_op(2'd3, {8'd0, 8'd9, 8'd7, 8'd100}, {8'd5, 8'd2, 8'd0, 8'd10}, 1'b0);
        chk("div_const", result_vec, 32'h0004FF0A);
        chk("div_mask", 32'(div_zero_mask), 32'b0010);

        // MUL and SUB wrap-around, with operands scrambled after the start edge.
        run_op(2'd2, {8'd3, 8'd15, 8'd2, 8'd16}, {8'd7, 8'd17, 8'd128, 8'd16}, 1'b1);
        chk("mul_lane0", 32'(result_vec[7:0]), 32'h00);
        run_op(2'd1, {8'd0, 8'd200, 8'd9, 8'd3}, {8'd1, 8'd100, 8'd9, 8'd5}, 1'b1);
        chk("sub_lane0", 32'(result_vec[7:0]), 32'hFE);
        chk("mask_cleared", 32'(div_zero_mask), 32'd0);

        // start held high: two runs back to back, with one IDLE cycle between them.
        start    = 1'b1;
        op_sel   = 2'd0;
        rs_vec   = {8'd4, 8'd3, 8'd2, 8'd1};
        rt_vec   = {8'd40, 8'd30, 8'd20, 8'd10};
        done_cnt = 0;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            p = (t - 1) % 6;
            chk($sformatf("held_busy_t%0d", t), 32'(busy), (p < 5) ? 32'd1 : 32'd0);
            chk($sformatf("held_done_t%0d", t), 32'(done), (p == 4) ? 32'd1 : 32'd0);
            if (p < 4) begin
                chk($sformatf("held_rs_t%0d", t), 32'(rs), 32'(p + 1));
            end
            if (done === 1'b1) begin
                done_cnt++;
            end
            if (t == 12) begin
                start = 1'b0;
            end
        end
        chk("held_done_count", 32'(done_cnt), 32'd2);
        chk("held_result", result_vec, {8'd44, 8'd33, 8'd22, 8'd11});

        // Reset asserted while lane 2 is issuing.
        start  = 1'b1;
        op_sel = 2'd0;
        rs_vec = {8'd9, 8'd9, 8'd9, 8'd9};
        rt_vec = {8'd1, 8'd1, 8'd1, 8'd1};
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_lane2_rs", 32'(rs), 32'd9);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_mux", 32'(alu_mux), 32'd0);
        chk("abort_rs", 32'(rs), 32'd0);
        chk("abort_result", result_vec, 32'd0);
        chk("abort_mask", 32'(div_zero_mask), 32'd0);
        @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        run_op(2'd3, {8'd200, 8'd0, 8'd50, 8'd9}, {8'd0, 8'd7, 8'd5, 8'd3}, 1'b0);

        // Randomized runs. Divisors sometimes land on zero.
        for (int n = 0; n < 10; n++) begin
            ra = $urandom;
            rb = $urandom;
            for (int k = 0; k < T; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rb[k*W +: W] = 8'd0;
                end
            end
            run_op(2'($urandom_range(0, 3)), ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
